tlb_lru_update: RTL and testbench
=================================

TLB_LRU_UPDATE -- requirements
Module: tlb_lru_update

Interface
- Parameters (name, default, meaning):
  - REQ-001 NUM_WAYS, 4, ways per set; width of the way index is 2.
  - REQ-002 LRU_BITS, 4, width of each per-way LRU counter.
  - REQ-003 NUM_SETS, 16, sets tracked; SET_BITS = log2(NUM_SETS) = 4.
- Ports (name, direction, width, meaning):
  - REQ-004 clk, input, 1, the block's only clock; all state updates on its rising edge.
  - REQ-005 rst, input, 1, synchronous, active-high reset.
  - REQ-006 acc_valid, input, 1, access (hit or fill) request for one set and way.
  - REQ-007 acc_set, input, SET_BITS, set index of the access.
  - REQ-008 acc_way, input, 2, way that was accessed.
  - REQ-009 acc_ready, output, 1, block can accept an access this cycle.
  - REQ-010 flush_req, input, 1, request to clear all counters; sampled only in IDLE.
  - REQ-011 flush_done, output, 1, one-cycle pulse when the flush completes.
  - REQ-012 upd_done, output, 1, one-cycle pulse in the cycle the access's counters are written.
  - REQ-013 rd_set, input, SET_BITS, read-port set index.
  - REQ-014 rd_lru, output, NUM_WAYS*LRU_BITS, counters of set rd_set, combinational from storage; way w is at bits [w*LRU_BITS +: LRU_BITS]. This port feeds the victim selector.

Function
- REQ-015 Storage: NUM_SETS x NUM_WAYS counters, LRU_BITS each; a larger value means more recently used.
- REQ-016 States: IDLE, UPDATE, RENORM, FLUSH.
- REQ-017 acc_ready = (state == IDLE) && !flush_req.
  - An access is accepted when acc_valid && acc_ready.
  - acc_set and acc_way are registered on acceptance, and the state goes to UPDATE.
- REQ-018 In IDLE, flush_req has priority over acc_valid; the state goes to FLUSH and the access is not accepted.
- REQ-019 UPDATE (one cycle): compute max, the largest counter of the registered set.
  - If max < 2^LRU_BITS-1: write counter[way] = max+1, pulse upd_done, and go to IDLE.
  - Otherwise go to RENORM, with no write.
- REQ-020 RENORM (one cycle):
  - Every counter of the set becomes counter >> 1.
  - The accessed way becomes 2^(LRU_BITS-1), which is 8 at the default width.
  - Pulse upd_done and go to IDLE.
  - Ordering among the other ways is preserved non-strictly; ties are permitted.
- REQ-021 The total latency from acceptance to the counter write is:
  - 1 cycle when no saturation occurs;
  - 2 cycles when saturation occurs.
- REQ-022 The accessed way holding the current max is still updated to max+1; there is no special case.
- REQ-023 FLUSH:
  - A set counter sweeps 0..NUM_SETS-1, one set per cycle, writing all of that set's counters to 0.
  - After set NUM_SETS-1 is written, pulse flush_done in that same cycle and go to IDLE.
  - The flush takes NUM_SETS cycles.
- REQ-024 acc_valid and flush_req are ignored outside IDLE; a flush_req during FLUSH does not restart the sweep.
- REQ-025 rd_lru reflects writes starting in the cycle after the write edge.
  - When rd_set equals the set being written, rd_lru shows the old values during the write cycle.
- REQ-026 All counter arithmetic is unsigned at LRU_BITS width; no write ever produces wrap-around.

Reset
- REQ-027 While rst is high at a clock edge, the following take effect at that edge:
  - state = IDLE;
  - all counters = 0;
  - upd_done = 0 and flush_done = 0;
  - the flush set counter = 0;
  - the registered access is cleared.
- REQ-028 A reset asserted in UPDATE, RENORM or FLUSH aborts the operation with no partial write at that edge.
  - acc_ready is 1 in the first cycle after rst deasserts, provided flush_req = 0.

Verification
- REQ-029 After reset, access set 3, way 2.
  - Response: 1 cycle later upd_done = 1.
  - The next cycle, rd_set = 3 gives rd_lru way 2 = 1 and all other ways = 0.
- REQ-030 Set 5 = {15, 3, 7, 0} for ways 0..3; access way 3.
  - Response: UPDATE then RENORM; set 5 = {7, 1, 3, 8}.
  - upd_done is high only in the RENORM cycle, and acc_ready is low for 2 cycles.
- REQ-031 flush_req and acc_valid high in the same IDLE cycle.
  - Response: acc_ready = 0 and the access is not taken.
  - flush_done pulses 16 cycles later, and all 64 counters = 0.
- REQ-032 Back-to-back accesses to set 0, ways 0, 1, 0, 1, each issued when acc_ready is high.
  - Response: set 0 = {3, 4, 0, 0}, and upd_done pulses 4 times.
- REQ-033 rst asserted in cycle 5 of a flush after set 7 = {1, 2, 3, 4} was loaded.
  - Response: all counters = 0 and flush_done is never pulsed.
- REQ-034 acc_valid held high during FLUSH.
  - Response: acc_ready = 0 throughout and the counters are unchanged by the access.
  - The access is accepted in the first IDLE cycle after flush_done.

Source files
------------

// File: rtl/tlb_lru_update_if.sv
// Access, flush and read-port bundle for the TLB LRU counter block.
interface tlb_lru_update_if #(
  parameter int SET_BITS = 4,
  parameter int WAY_BITS = 2,
  parameter int NUM_WAYS = 4,
  parameter int LRU_BITS = 4
);
  logic                         acc_valid;
  logic [SET_BITS-1:0]          acc_set;
  logic [WAY_BITS-1:0]          acc_way;
  logic                         acc_ready;
  logic                         flush_req;
  logic                         flush_done;
  logic                         upd_done;
  logic [SET_BITS-1:0]          rd_set;
  logic [NUM_WAYS*LRU_BITS-1:0] rd_lru;

  modport master (
    output acc_valid, acc_set, acc_way, flush_req, rd_set,
    input  acc_ready, flush_done, upd_done, rd_lru
  );

  modport slave (
    input  acc_valid, acc_set, acc_way, flush_req, rd_set,
    output acc_ready, flush_done, upd_done, rd_lru
  );
endinterface

// File: rtl/tlb_lru_update.sv
// Per-set LRU counter storage for a TLB: an access bumps the way to max+1,
// renormalising the set (halve all, accessed way = midpoint) on saturation.
// A flush sweeps every set to zero, one set per cycle.
module tlb_lru_update #(
  parameter int NUM_WAYS = 4,
  parameter int LRU_BITS = 4,
  parameter int NUM_SETS = 16
) (
  input logic            clk,
  input logic            rst,
  tlb_lru_update_if.slave bus
);
  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int WAY_BITS = $clog2(NUM_WAYS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] UPDATE = 2'd1;
  localparam logic [1:0] RENORM = 2'd2;
  localparam logic [1:0] FLUSH  = 2'd3;

  localparam logic [LRU_BITS-1:0] ONE      = LRU_BITS'(1);
  localparam logic [LRU_BITS-1:0] HALF     = LRU_BITS'(1) << (LRU_BITS - 1);
  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);

  logic [1:0]          state;
  logic [SET_BITS-1:0] set_q;
  logic [WAY_BITS-1:0] way_q;
  logic [SET_BITS-1:0] flush_set;
  logic [LRU_BITS-1:0] cnt [NUM_SETS][NUM_WAYS];
  logic [LRU_BITS-1:0] max_val;
  logic                saturated;

  // Largest counter of the registered set; saturation forces a renormalise.
  always_comb begin
    max_val = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (cnt[set_q][w] > max_val) max_val = cnt[set_q][w];
    end
    saturated = (max_val == '1);
  end

  // Handshake and completion pulses decode directly from the current state.
  always_comb begin
    bus.acc_ready  = (state == IDLE) && !bus.flush_req;
    bus.upd_done   = ((state == UPDATE) && !saturated) || (state == RENORM);
    bus.flush_done = (state == FLUSH) && (flush_set == LAST_SET);
  end

  // Read port shows stored counters; writes become visible the next cycle.
  always_comb begin
    bus.rd_lru = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      bus.rd_lru[w*LRU_BITS +: LRU_BITS] = cnt[bus.rd_set][w];
    end
  end

  // Control FSM and counter storage; reset wins over any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      set_q     <= '0;
      way_q     <= '0;
      flush_set <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          cnt[s][w] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            flush_set <= '0;
            state     <= FLUSH;
          end else if (bus.acc_valid) begin
            set_q <= bus.acc_set;
            way_q <= bus.acc_way;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          if (!saturated) begin
            cnt[set_q][way_q] <= max_val + ONE;
            state             <= IDLE;
          end else begin
            state <= RENORM;
          end
        end
        RENORM: begin
          for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            cnt[set_q][w] <= (WAY_BITS'(w) == way_q) ? HALF : (cnt[set_q][w] >> 1);
          end
          state <= IDLE;
        end
        FLUSH: begin
          for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            cnt[flush_set][w] <= '0;
          end
          if (flush_set == LAST_SET) state <= IDLE;
          else flush_set <= flush_set + SET_BITS'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlb_lru_update.sv
// Self-checking bench for tlb_lru_update: directed table, corner sequences
// and randomized accesses/flushes against an arithmetic reference model.
`timescale 1ns/1ps
module tb_tlb_lru_update;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlb_lru_update_if bus();

  tlb_lru_update dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int set;
    int way;
    int exp[4];
  } vec_t;

  int model[16][4];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int rd_way(input int w);
    logic [15:0] v;
    v = bus.rd_lru;
    return int'(v[w*4 +: 4]);
  endfunction

  task automatic model_clear;
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) model[s][w] = 0;
  endtask

  // Reference behaviour: newest way gets max+1; on saturation halve all and
  // park the accessed way at the midpoint 8.
  task automatic model_access(input int s, input int w, output int lat);
    int mx;
    mx = 0;
    for (int i = 0; i < 4; i++) if (model[s][i] > mx) mx = model[s][i];
    if (mx < 15) begin
      model[s][w] = mx + 1;
      lat = 1;
    end else begin
      for (int i = 0; i < 4; i++) model[s][i] = model[s][i] / 2;
      model[s][w] = 8;
      lat = 2;
    end
  endtask

  task automatic check_set(input int s);
    bus.rd_set = 4'(s);
    #1;
    for (int w = 0; w < 4; w++) check($sformatf("rd_lru set%0d way%0d", s, w), rd_way(w), model[s][w]);
  endtask

  task automatic check_all;
    for (int s = 0; s < 16; s++) begin
      check_set(s);
      tick;
    end
  endtask

  task automatic do_access(input int s, input int w);
    int lat;
    int waitc;
    waitc = 0;
    while (!bus.acc_ready && waitc < 20) begin
      tick;
      waitc++;
    end
    check("acc_ready before access", int'(bus.acc_ready), 1);
    bus.acc_valid = 1'b1;
    bus.acc_set   = 4'(s);
    bus.acc_way   = 2'(w);
    tick;
    bus.acc_valid = 1'b0;
    model_access(s, w, lat);
    check("acc_ready in UPDATE", int'(bus.acc_ready), 0);
    if (lat == 1) begin
      check("upd_done latency1", int'(bus.upd_done), 1);
    end else begin
      check("upd_done low in UPDATE", int'(bus.upd_done), 0);
      tick;
      check("acc_ready in RENORM", int'(bus.acc_ready), 0);
      check("upd_done in RENORM", int'(bus.upd_done), 1);
    end
    tick;
    check("upd_done one-cycle", int'(bus.upd_done), 0);
    check_set(s);
  endtask

  // Builds distinct nonzero targets from an all-zero set using max+1 steps.
  task automatic load_set(input int s, input int vals[4]);
    int maxv;
    int big;
    int hit;
    maxv = 0;
    big = 0;
    for (int i = 0; i < 4; i++) if (vals[i] > maxv) begin maxv = vals[i]; big = i; end
    for (int v = 1; v <= maxv; v++) begin
      hit = big;
      for (int i = 0; i < 4; i++) if (vals[i] == v) hit = i;
      do_access(s, hit);
    end
    check_set(s);
    for (int w = 0; w < 4; w++) check("load_set", rd_way(w), vals[w]);
  endtask

  task automatic do_flush;
    int cnt;
    bus.flush_req = 1'b1;
    #1;
    check("acc_ready with flush_req", int'(bus.acc_ready), 0);
    tick;
    bus.flush_req = 1'b0;
    cnt = 1;
    while (!bus.flush_done && cnt < 40) begin
      tick;
      cnt++;
    end
    check("flush cycles", cnt, 16);
    model_clear();
    tick;
  endtask

  vec_t tv[7];
  int   busy_ready;
  int   busy_upd;
  int   fd_seen;
  int   cnt;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{set: 3,  way: 2, exp: '{0, 0, 1, 0}};
    tv[1] = '{set: 0,  way: 0, exp: '{1, 0, 0, 0}};
    tv[2] = '{set: 0,  way: 1, exp: '{1, 2, 0, 0}};
    tv[3] = '{set: 0,  way: 0, exp: '{3, 2, 0, 0}};
    tv[4] = '{set: 0,  way: 1, exp: '{3, 4, 0, 0}};
    tv[5] = '{set: 3,  way: 2, exp: '{0, 0, 2, 0}};
    tv[6] = '{set: 15, way: 3, exp: '{0, 0, 0, 1}};

    rst = 1'b1;
    bus.acc_valid = 1'b0;
    bus.acc_set   = '0;
    bus.acc_way   = '0;
    bus.flush_req = 1'b0;
    bus.rd_set    = '0;
    model_clear();
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("reset upd_done", int'(bus.upd_done), 0);
    check("reset flush_done", int'(bus.flush_done), 0);
    check("reset acc_ready", int'(bus.acc_ready), 1);
    check_set(3);

    for (int i = 0; i < 7; i++) begin
      do_access(tv[i].set, tv[i].way);
      for (int w = 0; w < 4; w++) check($sformatf("table%0d way%0d", i, w), rd_way(w), tv[i].exp[w]);
    end

    // Reset during UPDATE must suppress the pending write.
    bus.acc_valid = 1'b1;
    bus.acc_set   = 4'd2;
    bus.acc_way   = 2'd0;
    tick;
    bus.acc_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_clear();
    check("acc_ready after reset", int'(bus.acc_ready), 1);
    check_set(2);
    check_set(0);

    // Saturating access: UPDATE then RENORM.
    load_set(5, '{15, 3, 7, 0});
    do_access(5, 3);
    begin
      int e[4];
      e = '{7, 1, 3, 8};
      for (int w = 0; w < 4; w++) check("renorm result", rd_way(w), e[w]);
    end

    // Flush and access in the same cycle; access held through the flush.
    bus.acc_valid = 1'b1;
    bus.acc_set   = 4'd9;
    bus.acc_way   = 2'd1;
    bus.flush_req = 1'b1;
    #1;
    check("ready low on flush+acc", int'(bus.acc_ready), 0);
    tick;
    bus.flush_req = 1'b0;
    cnt = 1;
    busy_ready = 0;
    busy_upd = 0;
    while (!bus.flush_done && cnt < 40) begin
      if (bus.acc_ready) busy_ready++;
      if (bus.upd_done) busy_upd++;
      bus.flush_req = (cnt == 8);
      tick;
      cnt++;
    end
    bus.flush_req = 1'b0;
    check("flush_done latency", cnt, 16);
    check("acc_ready during flush", busy_ready, 0);
    check("upd_done during flush", busy_upd, 0);
    model_clear();
    tick;
    check("acc_ready after flush", int'(bus.acc_ready), 1);
    tick;
    bus.acc_valid = 1'b0;
    check("held access upd_done", int'(bus.upd_done), 1);
    model[9][1] = 1;
    tick;
    check_all();

    // Reset in the middle of a flush: flush_done must never appear.
    load_set(7, '{1, 2, 3, 4});
    bus.flush_req = 1'b1;
    tick;
    bus.flush_req = 1'b0;
    fd_seen = 0;
    for (int c = 1; c < 5; c++) begin
      if (bus.flush_done) fd_seen++;
      tick;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("acc_ready after abort", int'(bus.acc_ready), 1);
    for (int c = 0; c < 20; c++) begin
      if (bus.flush_done) fd_seen++;
      tick;
    end
    check("flush_done after abort", fd_seen, 0);
    model_clear();
    check_all();

    // Randomized traffic on a few sets so saturation occurs often.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 29) == 0) do_flush();
      else do_access(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
